// File: rtl/accel_pkg.sv
// rtl/accel_pkg.sv - shared constants, derived widths and FSM state enum for the feed scheduler
package accel_pkg;

  localparam int DEF_BIT_WIDTH   = 8;
  localparam int DEF_NUM_CHANNEL = 3;
  localparam int DEF_NUM_KERNEL  = 4;
  localparam int DEF_REG_WIDTH   = 32;
  localparam int DEF_ADDR_WIDTH  = 16;

  localparam int DEF_DATA_WIDTH   = DEF_BIT_WIDTH * DEF_NUM_CHANNEL;
  localparam int DEF_WEIGHT_WIDTH = DEF_DATA_WIDTH * DEF_NUM_KERNEL;

  localparam int READ_LATENCY = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_STREAM = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_DONE   = 3'd4
  } feed_state_t;

endpackage

// File: rtl/accel_feed_addr_gen.sv
// rtl/accel_feed_addr_gen.sv - loadable read-address counter with remaining-word count
module accel_feed_addr_gen #(
  parameter int ADDR_WIDTH = 16,
  parameter int REG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] base,
  input  logic [REG_WIDTH-1:0]  count,
  input  logic                  step,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  last,
  output logic                  empty
);

  logic [REG_WIDTH-1:0] remaining;

  // Address wraps naturally at 2^ADDR_WIDTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= count;
    end else if (step) begin
      addr      <= addr + ADDR_WIDTH'(1);
      remaining <= remaining - REG_WIDTH'(1);
    end
  end

  assign last  = (remaining == REG_WIDTH'(1));
  assign empty = (remaining == '0);

endmodule

// File: rtl/accel_feed_scheduler.sv
// rtl/accel_feed_scheduler.sv - job sequencer feeding weights then pixels to the core; FEED_SCHED_STALL_CNT_EN adds stall counter
module accel_feed_scheduler
  import accel_pkg::*;
#(
  parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
  parameter int NUM_CHANNEL = DEF_NUM_CHANNEL,
  parameter int NUM_KERNEL  = DEF_NUM_KERNEL,
  parameter int REG_WIDTH   = DEF_REG_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      i_start,
  input  logic                                      i_abort,
  input  logic [REG_WIDTH-1:0]                      i_num_weight,
  input  logic [REG_WIDTH-1:0]                      i_num_pixel,
  input  logic [ADDR_WIDTH-1:0]                     i_weight_base,
  input  logic [ADDR_WIDTH-1:0]                     i_data_base,
  input  logic                                      i_core_req,
  output logic                                      o_wmem_en,
  output logic [ADDR_WIDTH-1:0]                     o_wmem_addr,
  input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] i_wmem_rdata,
  output logic                                      o_dmem_en,
  output logic [ADDR_WIDTH-1:0]                     o_dmem_addr,
  input  logic [BIT_WIDTH*NUM_CHANNEL-1:0]          i_dmem_rdata,
  output logic [BIT_WIDTH*NUM_CHANNEL*NUM_KERNEL-1:0] o_core_weight,
  output logic                                      o_core_weight_val,
  output logic [BIT_WIDTH*NUM_CHANNEL-1:0]          o_core_data,
  output logic                                      o_core_data_val,
  output logic                                      o_busy,
  output logic                                      o_done,
  output logic [REG_WIDTH-1:0]                      o_stall_cnt
);

  feed_state_t state, state_nxt;
  logic        start_acc;
  logic        w_last, w_empty, d_last, d_empty;
  logic        wval_q, dval_q;

  assign start_acc = (state == ST_IDLE) && i_start && !i_abort;

  accel_feed_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .REG_WIDTH(REG_WIDTH)) u_wgen (
    .clk   (clk),
    .rst   (rst),
    .load  (start_acc),
    .base  (i_weight_base),
    .count (i_num_weight),
    .step  (o_wmem_en),
    .addr  (o_wmem_addr),
    .last  (w_last),
    .empty (w_empty)
  );

  accel_feed_addr_gen #(.ADDR_WIDTH(ADDR_WIDTH), .REG_WIDTH(REG_WIDTH)) u_dgen (
    .clk   (clk),
    .rst   (rst),
    .load  (start_acc),
    .base  (i_data_base),
    .count (i_num_pixel),
    .step  (o_dmem_en),
    .addr  (o_dmem_addr),
    .last  (d_last),
    .empty (d_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_num_weight != '0)     state_nxt = ST_LOAD_W;
          else if (i_num_pixel != '0) state_nxt = ST_STREAM;
          else                        state_nxt = ST_DONE;
        end
      end
      ST_LOAD_W: begin
        // d_empty still reflects the latched pixel count: the data counter is untouched until STREAM.
        if (i_core_req && w_last) state_nxt = d_empty ? ST_DRAIN : ST_STREAM;
      end
      ST_STREAM: begin
        if (i_core_req && d_last) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
    if (i_abort) state_nxt = ST_IDLE;
  end

  always_comb begin
    o_wmem_en = (state == ST_LOAD_W) && i_core_req && !i_abort;
    o_dmem_en = (state == ST_STREAM) && i_core_req && !i_abort;
    o_busy    = (state != ST_IDLE);
    o_done    = (state == ST_DONE) && !i_abort;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wval_q <= 1'b0;
      dval_q <= 1'b0;
    end else begin
      wval_q <= o_wmem_en;
      dval_q <= o_dmem_en;
    end
  end

  // An abort also kills the word returning from the read issued one cycle earlier.
  assign o_core_weight_val = wval_q & ~i_abort;
  assign o_core_data_val   = dval_q & ~i_abort;
  assign o_core_weight     = i_wmem_rdata;
  assign o_core_data       = i_dmem_rdata;

`ifdef FEED_SCHED_STALL_CNT_EN
  logic [REG_WIDTH-1:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (start_acc) begin
      stall_cnt <= '0;
    end else if (((state == ST_LOAD_W) || (state == ST_STREAM)) && !i_core_req
                 && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + REG_WIDTH'(1);
    end
  end

  assign o_stall_cnt = stall_cnt;
`else
  assign o_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_accel_feed_scheduler.sv
// tb/tb_accel_feed_scheduler.sv - scoreboard bench for accel_feed_scheduler
module tb_accel_feed_scheduler;
  import accel_pkg::*;

  localparam int AW = DEF_ADDR_WIDTH;
  localparam int RW = DEF_REG_WIDTH;
  localparam int WW = DEF_WEIGHT_WIDTH;
  localparam int DW = DEF_DATA_WIDTH;

`ifdef FEED_SCHED_STALL_CNT_EN
  localparam logic [RW-1:0] EXP_TOGGLE_STALL = 32'd5;
`else
  localparam logic [RW-1:0] EXP_TOGGLE_STALL = 32'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start, i_abort, i_core_req;
  logic [RW-1:0] i_num_weight, i_num_pixel;
  logic [AW-1:0] i_weight_base, i_data_base;
  logic          o_wmem_en, o_dmem_en;
  logic [AW-1:0] o_wmem_addr, o_dmem_addr;
  logic [WW-1:0] i_wmem_rdata = '0;
  logic [DW-1:0] i_dmem_rdata = '0;
  logic [WW-1:0] o_core_weight;
  logic [DW-1:0] o_core_data;
  logic          o_core_weight_val, o_core_data_val;
  logic          o_busy, o_done;
  logic [RW-1:0] o_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  bit prev_wen = 1'b0;
  bit prev_den = 1'b0;

  logic [AW-1:0] exp_wa_q[$];
  logic [AW-1:0] exp_da_q[$];
  logic [WW-1:0] exp_wd_q[$];
  logic [DW-1:0] exp_dd_q[$];

  accel_feed_scheduler dut (
    .clk               (clk),
    .rst               (rst),
    .i_start           (i_start),
    .i_abort           (i_abort),
    .i_num_weight      (i_num_weight),
    .i_num_pixel       (i_num_pixel),
    .i_weight_base     (i_weight_base),
    .i_data_base       (i_data_base),
    .i_core_req        (i_core_req),
    .o_wmem_en         (o_wmem_en),
    .o_wmem_addr       (o_wmem_addr),
    .i_wmem_rdata      (i_wmem_rdata),
    .o_dmem_en         (o_dmem_en),
    .o_dmem_addr       (o_dmem_addr),
    .i_dmem_rdata      (i_dmem_rdata),
    .o_core_weight     (o_core_weight),
    .o_core_weight_val (o_core_weight_val),
    .o_core_data       (o_core_data),
    .o_core_data_val   (o_core_data_val),
    .o_busy            (o_busy),
    .o_done            (o_done),
    .o_stall_cnt       (o_stall_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WW-1:0] wpat(input logic [AW-1:0] a);
    return {6{a ^ 16'h5a5a}};
  endfunction

  function automatic logic [DW-1:0] dpat(input logic [AW-1:0] a);
    return {a ^ 16'h3c3c, a[7:0]};
  endfunction

  // Single-port RAM models with one cycle of read latency.
  always @(posedge clk) begin
    if (o_wmem_en) i_wmem_rdata <= wpat(o_wmem_addr);
    if (o_dmem_en) i_dmem_rdata <= dpat(o_dmem_addr);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_wen = 1'b0;
      prev_den = 1'b0;
    end else begin
      check("one_en", o_wmem_en & o_dmem_en, 0);
      if (o_wmem_en) begin
        check("w_req", i_core_req, 1);
        if (exp_wa_q.size() == 0) check("w_extra_rd", exp_wa_q.size(), 1);
        else check("w_addr", o_wmem_addr, exp_wa_q.pop_front());
      end
      if (o_dmem_en) begin
        check("d_req", i_core_req, 1);
        if (exp_da_q.size() == 0) check("d_extra_rd", exp_da_q.size(), 1);
        else check("d_addr", o_dmem_addr, exp_da_q.pop_front());
      end
      if (o_core_weight_val) begin
        if (exp_wd_q.size() == 0) check("w_extra_val", exp_wd_q.size(), 1);
        else check("w_data", o_core_weight, exp_wd_q.pop_front());
      end
      if (o_core_data_val) begin
        if (exp_dd_q.size() == 0) check("d_extra_val", exp_dd_q.size(), 1);
        else check("d_data", o_core_data, exp_dd_q.pop_front());
      end
      check("w_lat", o_core_weight_val, prev_wen & ~i_abort);
      check("d_lat", o_core_data_val, prev_den & ~i_abort);
      prev_wen = o_wmem_en;
      prev_den = o_dmem_en;
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic push_exp(input int nw, input int np, input logic [AW-1:0] wb,
                          input logic [AW-1:0] db);
    logic [AW-1:0] a;
    for (int i = 0; i < nw; i++) begin
      a = wb + AW'(i);
      exp_wa_q.push_back(a);
      exp_wd_q.push_back(wpat(a));
    end
    for (int i = 0; i < np; i++) begin
      a = db + AW'(i);
      exp_da_q.push_back(a);
      exp_dd_q.push_back(dpat(a));
    end
  endtask

  task automatic run_job(input int nw, input int np, input logic [AW-1:0] wb,
                         input logic [AW-1:0] db, input bit toggle, input int restart_at,
                         input logic [RW-1:0] exp_stall);
    int  c0, snap, exp_rel;
    bit  seen;
    push_exp(nw, np, wb, db);
    i_num_weight  = RW'(nw);
    i_num_pixel   = RW'(np);
    i_weight_base = wb;
    i_data_base   = db;
    i_core_req    = ~toggle;
    i_start       = 1'b1;
    snap          = done_cnt;
    tick();
    c0         = cyc;
    i_start    = 1'b0;
    i_core_req = 1'b1;
    seen       = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      #1;
      if (done_cnt != snap) begin
        seen = 1'b1;
        break;
      end
      tick();
      if (toggle) i_core_req = ~i_core_req;
      i_start = (k == restart_at);
      if (k == restart_at) begin
        i_num_weight  = 32'd9;
        i_num_pixel   = 32'd9;
        i_weight_base = 16'h0999;
        i_data_base   = 16'h0777;
      end
    end
    i_start = 1'b0;
    if (!seen) begin
      check("done_timeout", 0, 1);
    end else begin
      // Edges counted from the one that accepted the start to the one that entered DONE.
      exp_rel = (nw + np == 0) ? 0 : (toggle ? 2 * (nw + np) : nw + np + 1);
      check("done_lat", done_cyc - c0, exp_rel);
      check("done_once", done_cnt - snap, 1);
    end
    tick();
    i_core_req = 1'b1;
    check("idle_busy", o_busy, 0);
    check("idle_done", o_done, 0);
    check("stall_cnt", o_stall_cnt, exp_stall);
    check("wq_empty", exp_wa_q.size() + exp_wd_q.size(), 0);
    check("dq_empty", exp_da_q.size() + exp_dd_q.size(), 0);
  endtask

  initial begin
    int snap;
    rst = 1'b1;
    i_start = 1'b0;
    i_abort = 1'b0;
    i_core_req = 1'b0;
    i_num_weight = '0;
    i_num_pixel = '0;
    i_weight_base = '0;
    i_data_base = '0;
    repeat (3) tick();
    check("rst_busy", o_busy, 0);
    check("rst_done", o_done, 0);
    check("rst_wen", o_wmem_en, 0);
    check("rst_den", o_dmem_en, 0);
    check("rst_wval", o_core_weight_val, 0);
    check("rst_dval", o_core_data_val, 0);
    check("rst_waddr", o_wmem_addr, 0);
    check("rst_daddr", o_dmem_addr, 0);
    check("rst_stall", o_stall_cnt, 0);
    rst = 1'b0;
    tick();

    run_job(2, 4, 16'h0010, 16'h0040, 1'b0, -1, 32'd0);
    run_job(2, 4, 16'h0010, 16'h0040, 1'b1, -1, EXP_TOGGLE_STALL);
    check("stall_hold", o_stall_cnt, EXP_TOGGLE_STALL);
    run_job(0, 0, 16'h0010, 16'h0040, 1'b0, -1, 32'd0);
    run_job(0, 3, 16'h0020, 16'hFFFE, 1'b0, -1, 32'd0);
    run_job(3, 0, 16'hFFFF, 16'h0000, 1'b0, -1, 32'd0);

    // Abort lands on the third data read: only one weight and two data reads go out.
    snap = done_cnt;
    exp_wa_q.push_back(16'h0005);
    exp_wd_q.push_back(wpat(16'h0005));
    exp_da_q.push_back(16'h0060);
    exp_da_q.push_back(16'h0061);
    exp_dd_q.push_back(dpat(16'h0060));
    i_num_weight  = 32'd1;
    i_num_pixel   = 32'd5;
    i_weight_base = 16'h0005;
    i_data_base   = 16'h0060;
    i_core_req    = 1'b1;
    i_start       = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (3) tick();
    i_abort = 1'b1;
    @(negedge clk);
    #1;
    check("abort_den", o_dmem_en, 0);
    check("abort_dval", o_core_data_val, 0);
    tick();
    i_abort = 1'b0;
    check("abort_idle", o_busy, 0);
    check("abort_val", o_core_data_val, 0);
    check("abort_no_done", done_cnt - snap, 0);
    run_job(1, 2, 16'h0030, 16'h0050, 1'b0, -1, 32'd0);

    run_job(3, 3, 16'h0070, 16'h0080, 1'b0, 2, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
